peak_compress: RTL

PEAK_COMPRESS -- requirements
Module: peak_compress

---
 rtl/peak_compress.sv | 121 ++++++++++++
 1 files changed

// File: rtl/peak_compress.sv
// peak_compress: per-band peak-hold/decay followed by log-style compression, 2-stage AXI-Stream pipeline.
// Optional macro PEAK_COMPRESS_PEAK_HOLD_EN builds in the per-band peak/hold storage; otherwise stage 1 passes samples through.
module peak_compress #(
  parameter int BANDS            = 32,
  parameter int DATA_WIDTH       = 16,
  parameter int PEAK_HOLD_FRAMES = 3,
  parameter int DECAY_SHIFT      = 3
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  err_len
);

  localparam int IDX_W = $clog2(BANDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANDS - 1);

  logic                  en;
  logic                  acc;
  logic                  at_last;
  logic [IDX_W-1:0]      idx;
  logic                  s1_valid;
  logic                  s1_last;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] s1_next;

  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en;
  assign acc           = s_axis_tvalid && en;
  assign at_last       = (idx == LAST_IDX);

  // Output = {MSB index + 1, 4 bits below the MSB left-aligned, 7 zero bits}.
  function automatic logic [15:0] compress(input logic [15:0] x);
    logic [3:0]  p;
    logic [15:0] norm;
    p = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (x[i]) p = 4'(i);
    end
    norm = x << (4'd15 - p);
    compress = (x == '0) ? '0 : {5'(p) + 5'd1, norm[14:11], 7'b0};
  endfunction

`ifdef PEAK_COMPRESS_PEAK_HOLD_EN
  localparam int HOLD_W = (PEAK_HOLD_FRAMES > 0) ? $clog2(PEAK_HOLD_FRAMES + 1) : 1;

  logic [DATA_WIDTH-1:0] peak [BANDS];
  logic [HOLD_W-1:0]     hold [BANDS];
  logic [DATA_WIDTH-1:0] cur_peak;
  logic [DATA_WIDTH-1:0] decayed;
  logic [HOLD_W-1:0]     hold_next;

  always_comb begin
    cur_peak  = peak[idx];
    decayed   = cur_peak - (cur_peak >> DECAY_SHIFT);
    hold_next = hold[idx];
    s1_next   = cur_peak;
    if (s_axis_tdata >= cur_peak) begin
      s1_next   = s_axis_tdata;
      hold_next = HOLD_W'(PEAK_HOLD_FRAMES);
    end else if (hold[idx] != '0) begin
      hold_next = hold[idx] - 1'b1;
    end else begin
      s1_next = (s_axis_tdata > decayed) ? s_axis_tdata : decayed;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < BANDS; b++) begin
        peak[b] <= '0;
        hold[b] <= '0;
      end
    end else if (acc) begin
      peak[idx] <= s1_next;
      hold[idx] <= hold_next;
    end
  end
`else
  always_comb begin
    s1_next = s_axis_tdata;
  end
`endif

  // Band index and sticky length error track accepted beats only.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      err_len <= 1'b0;
    end else if (acc) begin
      if (s_axis_tlast != at_last) err_len <= 1'b1;
      idx <= (s_axis_tlast || at_last) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s1_data       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (en) begin
      s1_valid      <= acc;
      s1_last       <= s_axis_tlast;
      s1_data       <= s1_next;
      m_axis_tvalid <= s1_valid;
      m_axis_tlast  <= s1_last;
      m_axis_tdata  <= compress(s1_data);
    end
  end

endmodule
